// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scan sequencer for a 4-digit multiplexed seven-segment display.
// Time-slices four nibbles onto one shared decoder, inserts an all-off
// dead-time before each digit and swaps double-buffered digit values only at
// frame boundaries. Optional leading-zero blanking is built when LZB_EN is
// defined.
module seg_scan_ctrl #(
   parameter int TICK_DIV = 50000,
   parameter int DEAD_CYC = 16,
   parameter int CNT_W    = 16
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic        en,
   input  logic        load,
   input  logic [15:0] digits_in,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blank_mask,
   output logic [3:0]  an,
   output logic [3:0]  digit_code,
   output logic        dp_out,
   output logic [1:0]  slot,
   output logic        frame_done
);

   typedef enum logic [1:0] {IDLE, DEAD, SHOW} state_t;

   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] DEAD_LAST = (DEAD_CYC == 0) ? '0 : CNT_W'(DEAD_CYC - 1);
   localparam state_t           SLOT_ENTRY = (DEAD_CYC == 0) ? SHOW : DEAD;

   state_t            state, nxt_state;
   logic [CNT_W-1:0]  cnt, nxt_cnt;
   logic [1:0]        nxt_slot;
   logic [15:0]       stage_dig, disp_dig, nxt_disp_dig;
   logic [3:0]        stage_dp, disp_dp, nxt_disp_dp;
   logic              pending;
   logic              swap, wrap;
   logic [3:0]        lz_blank, blank, nxt_an;

   // Next-state decode; outputs are then registered from these next values
   // so they line up with the state register they describe.
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_slot  = slot;
      swap      = 1'b0;
      wrap      = 1'b0;
      if (!en) begin
         nxt_state = IDLE;
         nxt_cnt   = '0;
         nxt_slot  = 2'd0;
      end else begin
         case (state)
            IDLE: begin
               nxt_state = SLOT_ENTRY;
               nxt_cnt   = '0;
               nxt_slot  = 2'd0;
               swap      = pending;
            end
            DEAD: begin
               nxt_cnt = cnt + CNT_W'(1);
               if (cnt == DEAD_LAST)
                  nxt_state = SHOW;
            end
            SHOW: begin
               if (cnt == TICK_LAST) begin
                  nxt_cnt   = '0;
                  nxt_slot  = slot + 2'd1;
                  nxt_state = SLOT_ENTRY;
                  if (slot == 2'd3) begin
                     wrap = 1'b1;
                     swap = pending;
                  end
               end else begin
                  nxt_cnt = cnt + CNT_W'(1);
               end
            end
            default: begin
               nxt_state = IDLE;
               nxt_cnt   = '0;
               nxt_slot  = 2'd0;
            end
         endcase
      end
      nxt_disp_dig = swap ? stage_dig : disp_dig;
      nxt_disp_dp  = swap ? stage_dp  : disp_dp;
   end

`ifdef LZB_EN
   // Leading-zero suppression chain; a set decimal point breaks the chain.
   always_comb begin
      lz_blank    = '0;
      lz_blank[3] = (nxt_disp_dig[15:12] == 4'd0) && !nxt_disp_dp[3];
      lz_blank[2] = lz_blank[3] && (nxt_disp_dig[11:8] == 4'd0) && !nxt_disp_dp[2];
      lz_blank[1] = lz_blank[2] && (nxt_disp_dig[7:4]  == 4'd0) && !nxt_disp_dp[1];
   end
`else
   // No leading-zero suppression in this build.
   always_comb begin
      lz_blank = '0;
   end
`endif

   // Anode pattern for the upcoming cycle: at most one anode low, only in SHOW.
   always_comb begin
      blank  = blank_mask | lz_blank;
      nxt_an = '1;
      if (nxt_state == SHOW && !blank[nxt_slot])
         nxt_an[nxt_slot] = 1'b0;
   end

   // FSM, buffers and registered outputs. A load on a swap cycle lands in
   // staging after the swap, so it stays pending for the next boundary.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         slot       <= 2'd0;
         stage_dig  <= '0;
         stage_dp   <= '0;
         disp_dig   <= '0;
         disp_dp    <= '0;
         pending    <= 1'b0;
         an         <= '1;
         digit_code <= '0;
         dp_out     <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= nxt_state;
         cnt        <= nxt_cnt;
         slot       <= nxt_slot;
         disp_dig   <= nxt_disp_dig;
         disp_dp    <= nxt_disp_dp;
         if (swap)
            pending <= 1'b0;
         if (load) begin
            stage_dig <= digits_in;
            stage_dp  <= dp_in;
            pending   <= 1'b1;
         end
         an         <= nxt_an;
         frame_done <= wrap;
         if (nxt_state == IDLE) begin
            digit_code <= '0;
            dp_out     <= 1'b0;
         end else begin
            digit_code <= nxt_disp_dig[{nxt_slot, 2'b00} +: 4];
            dp_out     <= nxt_disp_dp[nxt_slot];
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl with TICK_DIV=8, DEAD_CYC=2.
// Leading-zero expectations follow LZB_EN when the macro is defined.
module tb_seg_scan_ctrl;

   logic        clk_in;
   logic        rst;
   logic        en;
   logic        load;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic [3:0]  blank_mask;
   logic [3:0]  an;
   logic [3:0]  digit_code;
   logic        dp_out;
   logic [1:0]  slot;
   logic        frame_done;

   int errors = 0;
   int checks = 0;

   seg_scan_ctrl #(
      .TICK_DIV (8),
      .DEAD_CYC (2),
      .CNT_W    (16)
   ) dut (
      .clk_in     (clk_in),
      .rst        (rst),
      .en         (en),
      .load       (load),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .blank_mask (blank_mask),
      .an         (an),
      .digit_code (digit_code),
      .dp_out     (dp_out),
      .slot       (slot),
      .frame_done (frame_done)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Runs one 32-cycle frame, starting just before the edge into slot 0.
   // Optional loads are applied before edges k = ld_pos .. ld_pos+ld_n-1.
   task automatic run_frame(input logic [15:0] digs, input logic [3:0] dps,
                            input logic [3:0] dark, input bit fd0,
                            input int ld_pos, input int ld_n,
                            input logic [15:0] ld_d0, input logic [15:0] ld_d1,
                            input logic [3:0] ld_dp);
      logic [3:0] exp_an;
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 8; c++) begin
            int k;
            k = s * 8 + c;
            if (ld_pos >= 0 && k >= ld_pos && k < ld_pos + ld_n) begin
               load      = 1'b1;
               digits_in = (k == ld_pos) ? ld_d0 : ld_d1;
               dp_in     = ld_dp;
            end else begin
               load = 1'b0;
            end
            step();
            exp_an = 4'b1111;
            if (c >= 2 && !dark[s])
               exp_an[s] = 1'b0;
            chk($sformatf("an s%0d c%0d", s, c), {12'b0, an}, {12'b0, exp_an});
            chk($sformatf("slot s%0d c%0d", s, c), {14'b0, slot}, 16'(s));
            chk($sformatf("code s%0d c%0d", s, c), {12'b0, digit_code}, {12'b0, digs[s*4 +: 4]});
            chk($sformatf("dp s%0d c%0d", s, c), {15'b0, dp_out}, {15'b0, dps[s]});
            chk($sformatf("fdone s%0d c%0d", s, c), {15'b0, frame_done},
                {15'b0, (k == 0) ? fd0 : 1'b0});
         end
      end
      load = 1'b0;
   endtask

   logic [3:0] lz_0050;

   initial begin
`ifdef LZB_EN
      lz_0050 = 4'b1100;
`else
      lz_0050 = 4'b0000;
`endif
      // Reset, with en and load asserted to show reset wins
      rst = 1'b1; en = 1'b1; load = 1'b1;
      digits_in = 16'hFFFF; dp_in = 4'hF; blank_mask = 4'b0000;
      step(); step();
      chk("rst an", {12'b0, an}, 16'h000F);
      chk("rst code", {12'b0, digit_code}, 16'h0000);
      chk("rst dp", {15'b0, dp_out}, 16'h0000);
      chk("rst slot", {14'b0, slot}, 16'h0000);
      chk("rst fdone", {15'b0, frame_done}, 16'h0000);

      // Idle after reset: dark, and a load while idle
      rst = 1'b0; en = 1'b0; load = 1'b1; digits_in = 16'h8765; dp_in = 4'b0001;
      step();
      load = 1'b0;
      chk("idle an", {12'b0, an}, 16'h000F);
      chk("idle slot", {14'b0, slot}, 16'h0000);

      // Enable: idle load applied on exit; basic slot timing
      en = 1'b1;
      run_frame(16'h8765, 4'b0001, 4'b0000, 1'b0, -1, 0, 16'h0, 16'h0, 4'h0);

      // Mid-frame load held until the boundary
      run_frame(16'h8765, 4'b0001, 4'b0000, 1'b1, 11, 1, 16'h1234, 16'h0, 4'b0000);
      run_frame(16'h1234, 4'b0000, 4'b0000, 1'b1, -1, 0, 16'h0, 16'h0, 4'h0);

      // Back-to-back loads (last wins), then a load on the boundary cycle
      run_frame(16'h1234, 4'b0000, 4'b0000, 1'b1, 20, 2, 16'hAAAA, 16'h5555, 4'b0000);
      run_frame(16'h5555, 4'b0000, 4'b0000, 1'b1, 0, 1, 16'h9999, 16'h0, 4'b0010);
      run_frame(16'h9999, 4'b0010, 4'b0000, 1'b1, -1, 0, 16'h0, 16'h0, 4'h0);

      // Live blank mask on slot 2
      blank_mask = 4'b0100;
      run_frame(16'h9999, 4'b0010, 4'b0100, 1'b1, -1, 0, 16'h0, 16'h0, 4'h0);
      blank_mask = 4'b0000;

      // Drop en during SHOW of slot 2
      for (int i = 0; i < 20; i++) step();
      chk("pre-abort an", {12'b0, an}, 16'h000B);
      chk("pre-abort slot", {14'b0, slot}, 16'h0002);
      en = 1'b0;
      step();
      chk("abort an", {12'b0, an}, 16'h000F);
      chk("abort slot", {14'b0, slot}, 16'h0000);
      chk("abort fdone", {15'b0, frame_done}, 16'h0000);
      for (int i = 0; i < 40; i++) begin
         step();
         chk("idle fdone", {15'b0, frame_done}, 16'h0000);
         chk("idle an2", {12'b0, an}, 16'h000F);
      end

      // Load while idle, re-enable: restart at slot 0 with dead-time
      load = 1'b1; digits_in = 16'h0050; dp_in = 4'b0000;
      step();
      load = 1'b0;
      en = 1'b1;
      run_frame(16'h0050, 4'b0000, lz_0050, 1'b0, 5, 1, 16'h0050, 16'h0, 4'b1000);
      run_frame(16'h0050, 4'b1000, 4'b0000, 1'b1, -1, 0, 16'h0, 16'h0, 4'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
